// File: rtl/tube_pkg.sv
// Shared definitions for the Tube register 3 block-transfer sequencer:
// transfer type codes, the sequencer state encoding and small decode helpers.
package tube_pkg;

    // Transfer type codes as presented on cmd_type
    localparam logic [1:0] XFER_P2H_1 = 2'd0;  // parasite to host, single byte mode
    localparam logic [1:0] XFER_H2P_1 = 2'd1;  // host to parasite, single byte mode
    localparam logic [1:0] XFER_P2H_2 = 2'd2;  // parasite to host, byte pairs
    localparam logic [1:0] XFER_H2P_2 = 2'd3;  // host to parasite, byte pairs

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHK    = 3'd1,
        ST_FRD    = 3'd2,
        ST_MWR    = 3'd3,
        ST_MRD    = 3'd4,
        ST_FWR    = 3'd5,
        ST_SETTLE = 3'd6,
        ST_FIN    = 3'd7
    } xfer_state_e;

    // Pair transfers use two-byte FIFO mode
    function automatic logic is_pair(input logic [1:0] xfer_type);
        return xfer_type[1];
    endfunction

    // Host-to-parasite transfers read the register 3 FIFO
    function automatic logic is_h2p(input logic [1:0] xfer_type);
        return xfer_type[0];
    endfunction

endpackage

// File: rtl/tube_xfer_cnt.sv
// Address incrementer and remaining-byte down-counter for the register 3
// transfer sequencer. Loaded at command accept, stepped once per byte moved.
module tube_xfer_cnt #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  remaining,
    output logic              last
);

    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  remaining_r;

    // Address and count registers: load wins over step; address wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r      <= {ADDR_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
        end else if (load) begin
            addr_r      <= load_addr;
            remaining_r <= load_count;
        end else if (step && (remaining_r != {CNT_W{1'b0}})) begin
            addr_r      <= addr_r + ADDR_W'(1);
            remaining_r <= remaining_r - CNT_W'(1);
        end else begin
            addr_r      <= addr_r;
            remaining_r <= remaining_r;
        end
    end

    assign addr      = addr_r;
    assign remaining = remaining_r;
    // The byte currently being moved is the final one
    assign last      = (remaining_r == CNT_W'(1));

endmodule

// File: rtl/tube_r3_xfer_ctrl.sv
// Parasite-side sequencer for Tube register 3 block transfers. Moves a
// counted block of bytes between the register 3 FIFO pair and parasite
// memory through a req/ack memory port, in single-byte or byte-pair mode.
module tube_r3_xfer_ctrl
    import tube_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              p_phi2,
    input  logic              p_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              abort,
    output logic              r3_sel,
    output logic              r3_rdnw,
    output logic [7:0]        r3_wdata,
    input  logic [7:0]        r3_rdata,
    input  logic              r3_data_available,
    input  logic              r3_two_bytes_available,
    input  logic              r3_not_full,
    output logic              one_byte_mode,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  remaining
);

    xfer_state_e       state_r;
    xfer_state_e       state_nxt_s;

    logic [1:0]        type_r;         // latched transfer type
    logic              second_r;       // current byte is the second of a pair
    logic [7:0]        data_r;         // byte in flight between FIFO and memory
    logic              abort_r;        // abort seen while a memory access is open
    logic              obm_r;          // one_byte_mode register
    logic              done_r;
    logic              err_r;

    logic              accept_s;
    logic              cmd_zero_s;
    logic              cmd_bad_s;
    logic              load_s;
    logic              start_s;
    logic              step_s;
    logic              status_ok_s;
    logic              abort_seen_s;
    logic              pair_s;
    logic              h2p_s;
    logic [ADDR_W-1:0] addr_s;
    logic [CNT_W-1:0]  rem_s;
    logic              last_s;

    // Command handshake decode
    assign accept_s   = cmd_valid && (state_r == ST_IDLE);
    assign cmd_zero_s = (cmd_count == {CNT_W{1'b0}});
    assign cmd_bad_s  = is_pair(cmd_type) && cmd_count[0];
    assign load_s     = accept_s && !cmd_bad_s;
    assign start_s    = load_s && !cmd_zero_s;

    assign pair_s       = is_pair(type_r);
    assign h2p_s        = is_h2p(type_r);
    assign abort_seen_s = abort_r || abort;

    // A byte is retired when its memory write acks (H->P) or its FIFO write strobes (P->H)
    assign step_s = ((state_r == ST_MWR) && mem_ack) || (state_r == ST_FWR);

    // FIFO status gate sampled in CHK; only first bytes of pairs reach CHK in pair mode
    always_comb begin
        status_ok_s = 1'b0;
        if (h2p_s) begin
            if (pair_s) begin
                status_ok_s = r3_two_bytes_available;
            end else begin
                status_ok_s = r3_data_available;
            end
        end else begin
            status_ok_s = r3_not_full;
        end
    end

    tube_xfer_cnt #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk        (p_phi2),
        .rst        (p_rst),
        .load       (load_s),
        .load_addr  (cmd_addr),
        .load_count (cmd_count),
        .step       (step_s),
        .addr       (addr_s),
        .remaining  (rem_s),
        .last       (last_s)
    );

    // State register
    always_ff @(posedge p_phi2 or posedge p_rst) begin
        if (p_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = is_h2p(cmd_type) ? ST_CHK : ST_MRD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (abort) begin
                    state_nxt_s = ST_FIN;
                end else if (status_ok_s) begin
                    state_nxt_s = h2p_s ? ST_FRD : ST_FWR;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
            ST_FRD: begin
                if (abort) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_MWR;
                end
            end
            ST_MWR: begin
                if (!mem_ack) begin
                    state_nxt_s = ST_MWR;
                end else if (abort_seen_s || last_s) begin
                    state_nxt_s = ST_FIN;
                end else if (pair_s && !second_r) begin
                    state_nxt_s = ST_FRD;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_MRD: begin
                if (!mem_ack) begin
                    state_nxt_s = ST_MRD;
                end else if (abort_seen_s) begin
                    state_nxt_s = ST_FIN;
                end else if (second_r) begin
                    state_nxt_s = ST_FWR;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
            ST_FWR: begin
                if (abort || last_s) begin
                    state_nxt_s = ST_FIN;
                end else if (pair_s && !second_r) begin
                    state_nxt_s = ST_MRD;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = h2p_s ? ST_CHK : ST_MRD;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Strobe and request decode from the registered state
    always_comb begin
        r3_sel  = 1'b0;
        r3_rdnw = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (state_r)
            ST_FRD: begin
                r3_sel  = 1'b1;
                r3_rdnw = 1'b1;
            end
            ST_FWR: begin
                r3_sel  = 1'b1;
                r3_rdnw = 1'b0;
            end
            ST_MWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            ST_MRD: begin
                mem_req = 1'b1;
                mem_we  = 1'b0;
            end
            default: begin
                r3_sel  = 1'b0;
                r3_rdnw = 1'b0;
                mem_req = 1'b0;
                mem_we  = 1'b0;
            end
        endcase
    end

    // Command latch, data capture, pair phase, abort latch and status pulses
    always_ff @(posedge p_phi2 or posedge p_rst) begin
        if (p_rst) begin
            type_r   <= XFER_P2H_1;
            second_r <= 1'b0;
            data_r   <= 8'h00;
            abort_r  <= 1'b0;
            obm_r    <= 1'b1;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= (state_r == ST_FIN) || (accept_s && !cmd_bad_s && cmd_zero_s);
            err_r  <= accept_s && cmd_bad_s;

            if (load_s) begin
                type_r <= cmd_type;
                obm_r  <= !cmd_type[1];
            end

            if (state_r == ST_FRD) begin
                data_r <= r3_rdata;
            end else if ((state_r == ST_MRD) && mem_ack) begin
                data_r <= mem_rdata;
            end

            // mem_req is never withdrawn early, so abort is remembered until the ack
            if ((state_r == ST_MWR) || (state_r == ST_MRD)) begin
                abort_r <= abort_r || abort;
            end else begin
                abort_r <= 1'b0;
            end

            if (start_s) begin
                second_r <= 1'b0;
            end else if (step_s && pair_s) begin
                second_r <= !second_r;
            end
        end
    end

    assign cmd_ready     = (state_r == ST_IDLE) && !p_rst;
    assign busy          = (state_r != ST_IDLE);
    assign done          = done_r;
    assign err           = err_r;
    assign one_byte_mode = obm_r;
    assign remaining     = rem_s;
    assign mem_addr      = addr_s;
    assign mem_wdata     = data_r;
    assign r3_wdata      = data_r;

endmodule

// File: tb/tb_tube_r3_xfer_ctrl.sv
// Directed self-checking bench for tube_r3_xfer_ctrl with a behavioural
// memory responder and register 3 FIFO model.
module tb_tube_r3_xfer_ctrl;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    logic              p_phi2 = 1'b0;
    logic              p_rst  = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_type = 2'd0;
    logic [ADDR_W-1:0] cmd_addr = 16'h0000;
    logic [CNT_W-1:0]  cmd_count = 16'h0000;
    logic              abort = 1'b0;
    logic              r3_sel;
    logic              r3_rdnw;
    logic [7:0]        r3_wdata;
    logic [7:0]        r3_rdata = 8'h00;
    logic              r3_data_available;
    logic              r3_two_bytes_available;
    logic              r3_not_full;
    logic              one_byte_mode;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_ack = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  remaining;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // memory and FIFO models
    logic [7:0]  mem [0:65535];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [7:0]  h2p_bytes [0:15];
    int          h2p_wr = 0;
    int          rd_idx = 0;
    int          p2h_cnt = 0;
    int          p2h_cap = 16;
    // logs
    logic [15:0] wr_addr [0:15];
    logic [7:0]  wr_data [0:15];
    int          wr_n = 0;
    logic [15:0] mrd_addr [0:15];
    int          mrd_n = 0;
    int          fr_cyc [0:15];
    int          fr_n = 0;
    logic [7:0]  fw_data [0:15];
    int          fw_n = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    int          ack_cyc = 0;
    int          sel_total = 0;
    int          req_total = 0;
    int          viol = 0;
    logic        prev_sel = 1'b0;

    assign r3_data_available      = (h2p_wr - rd_idx) >= 1;
    assign r3_two_bytes_available = (h2p_wr - rd_idx) >= 2;
    assign r3_not_full            = (p2h_cnt < p2h_cap);

    tube_r3_xfer_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .p_phi2(p_phi2), .p_rst(p_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count), .abort(abort),
        .r3_sel(r3_sel), .r3_rdnw(r3_rdnw), .r3_wdata(r3_wdata), .r3_rdata(r3_rdata),
        .r3_data_available(r3_data_available),
        .r3_two_bytes_available(r3_two_bytes_available),
        .r3_not_full(r3_not_full), .one_byte_mode(one_byte_mode),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err), .remaining(remaining)
    );

    initial begin
        forever #5 p_phi2 = ~p_phi2;
    end

    always @(posedge p_phi2) cyc <= cyc + 1;

    // Responder and monitor, acting on the falling edge
    initial begin
        forever begin
            @(negedge p_phi2);
            if (done) begin done_n++; done_cyc = cyc; end
            if (r3_sel) sel_total++;
            if (mem_req) req_total++;
            if (r3_sel && (prev_sel || mem_req)) viol++;
            prev_sel = r3_sel;
            if (r3_sel && r3_rdnw) begin
                r3_rdata = h2p_bytes[rd_idx % 16];
                if (fr_n < 16) fr_cyc[fr_n] = cyc;
                fr_n++;
                rd_idx++;
            end
            if (r3_sel && !r3_rdnw) begin
                if (fw_n < 16) fw_data[fw_n] = r3_wdata;
                fw_n++;
                p2h_cnt++;
            end
            if (p_rst) begin
                mem_ack = 1'b0;
                wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    mem_ack = 1'b1;
                    ack_cyc = cyc;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        if (wr_n < 16) begin wr_addr[wr_n] = mem_addr; wr_data[wr_n] = mem_wdata; end
                        wr_n++;
                    end else begin
                        mem_rdata = mem[mem_addr];
                        if (mrd_n < 16) mrd_addr[mrd_n] = mem_addr;
                        mrd_n++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        wr_n = 0; mrd_n = 0; fr_n = 0; fw_n = 0;
        h2p_wr = 0; rd_idx = 0; p2h_cnt = 0; viol = 0; wait_cnt = 0;
    endtask

    task automatic push_h2p(input logic [7:0] b);
        h2p_bytes[h2p_wr % 16] = b;
        h2p_wr++;
    endtask

    task automatic issue_cmd(input logic [1:0] t, input logic [15:0] a, input logic [15:0] n);
        @(negedge p_phi2);
        cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_count = n;
        @(negedge p_phi2);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge p_phi2);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge p_phi2);
        @(negedge p_phi2);
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || r3_sel !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL reset_outputs: busy=%b req=%b sel=%b done=%b err=%b expected all 0", busy, mem_req, r3_sel, done, err); end
        checks++; if (one_byte_mode !== 1'b1) begin failures++; $display("FAIL reset_obm: got %b expected 1", one_byte_mode); end
        checks++; if (remaining !== 16'h0000) begin failures++; $display("FAIL reset_remaining: got %h expected 0000", remaining); end
        p_rst = 1'b0;
        @(negedge p_phi2);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_h2p_single();
        bit seen;
        clear_logs(); ack_delay = 0;
        push_h2p(8'hA1); push_h2p(8'hB2); push_h2p(8'hC3);
        issue_cmd(2'd1, 16'h1000, 16'd3);
        wait_done(200, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL h2p1_done: got %b expected 1", seen); end
        checks++; if (wr_n !== 3 || wr_addr[0] !== 16'h1000 || wr_data[0] !== 8'hA1 || wr_addr[1] !== 16'h1001 || wr_data[1] !== 8'hB2 || wr_addr[2] !== 16'h1002 || wr_data[2] !== 8'hC3) begin
            failures++; $display("FAIL h2p1_writes: n=%0d %h=%h %h=%h %h=%h expected 1000=A1 1001=B2 1002=C3", wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]); end
        checks++; if (fr_n !== 3) begin failures++; $display("FAIL h2p1_reads: got %0d expected 3", fr_n); end
        checks++; if (fr_cyc[1] - fr_cyc[0] !== 4 || fr_cyc[2] - fr_cyc[1] !== 4) begin
            failures++; $display("FAIL h2p1_settle_gap: got %0d,%0d expected 4,4", fr_cyc[1] - fr_cyc[0], fr_cyc[2] - fr_cyc[1]); end
        checks++; if (remaining !== 16'h0000 || one_byte_mode !== 1'b1) begin failures++; $display("FAIL h2p1_state: rem=%h obm=%b expected 0000 1", remaining, one_byte_mode); end
        @(negedge p_phi2);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL h2p1_done_pulse: done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL h2p1_strobe_rules: got %0d expected 0", viol); end
    endtask

    task automatic test_h2p_pair();
        bit seen;
        clear_logs(); ack_delay = 0;
        issue_cmd(2'd3, 16'h1100, 16'd4);
        repeat (6) @(negedge p_phi2);
        checks++; if (fr_n !== 0 || busy !== 1'b1 || one_byte_mode !== 1'b0) begin
            failures++; $display("FAIL h2p2_wait_pair: reads=%0d busy=%b obm=%b expected 0 1 0", fr_n, busy, one_byte_mode); end
        push_h2p(8'h11); push_h2p(8'h22);
        for (int i = 0; i < 50 && fr_n < 2; i++) @(negedge p_phi2);
        repeat (6) @(negedge p_phi2);
        checks++; if (fr_n !== 2) begin failures++; $display("FAIL h2p2_first_pair: reads=%0d expected 2", fr_n); end
        checks++; if (fr_cyc[1] - fr_cyc[0] !== 2) begin failures++; $display("FAIL h2p2_pair_gap: got %0d expected 2", fr_cyc[1] - fr_cyc[0]); end
        push_h2p(8'h33); push_h2p(8'h44);
        wait_done(200, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL h2p2_done: got %b expected 1", seen); end
        checks++; if (wr_n !== 4 || wr_addr[0] !== 16'h1100 || wr_data[0] !== 8'h11 || wr_data[1] !== 8'h22 || wr_addr[3] !== 16'h1103 || wr_data[2] !== 8'h33 || wr_data[3] !== 8'h44) begin
            failures++; $display("FAIL h2p2_writes: n=%0d a0=%h d=%h %h %h %h a3=%h expected 4 1100 11 22 33 44 1103", wr_n, wr_addr[0], wr_data[0], wr_data[1], wr_data[2], wr_data[3], wr_addr[3]); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL h2p2_strobe_rules: got %0d expected 0", viol); end
    endtask

    task automatic test_p2h_pair_wrap();
        bit seen;
        clear_logs(); ack_delay = 0; p2h_cap = 0;
        mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
        issue_cmd(2'd2, 16'hFFFF, 16'd2);
        repeat (5) @(negedge p_phi2);
        checks++; if (fw_n !== 0 || one_byte_mode !== 1'b0) begin failures++; $display("FAIL p2h2_wait_full: writes=%0d obm=%b expected 0 0", fw_n, one_byte_mode); end
        p2h_cap = 1;
        wait_done(200, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL p2h2_done: got %b expected 1", seen); end
        checks++; if (fw_n !== 2 || fw_data[0] !== 8'h5A || fw_data[1] !== 8'hA5) begin
            failures++; $display("FAIL p2h2_fifo_data: n=%0d %h %h expected 2 5A A5", fw_n, fw_data[0], fw_data[1]); end
        checks++; if (mrd_n !== 2 || mrd_addr[0] !== 16'hFFFF || mrd_addr[1] !== 16'h0000) begin
            failures++; $display("FAIL p2h2_wrap_addr: n=%0d %h %h expected 2 FFFF 0000", mrd_n, mrd_addr[0], mrd_addr[1]); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL p2h2_strobe_rules: got %0d expected 0", viol); end
        p2h_cap = 16;
    endtask

    task automatic test_err_and_zero();
        int sel0, req0;
        clear_logs();
        sel0 = sel_total; req0 = req_total;
        issue_cmd(2'd3, 16'h2000, 16'd5);
        checks++; if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL odd_pair_err: err=%b busy=%b ready=%b expected 1 0 1", err, busy, cmd_ready); end
        @(negedge p_phi2);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL odd_pair_err_pulse: got %b expected 0", err); end
        issue_cmd(2'd2, 16'h2000, 16'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL zero_count_done: done=%b busy=%b err=%b expected 1 0 0", done, busy, err); end
        repeat (3) @(negedge p_phi2);
        checks++; if (sel_total !== sel0 || req_total !== req0) begin
            failures++; $display("FAIL err_zero_no_access: sel=%0d req=%0d expected %0d %0d", sel_total, req_total, sel0, req0); end
    endtask

    task automatic test_abort_in_mwr();
        bit seen;
        bit got_req;
        clear_logs(); ack_delay = 4;
        push_h2p(8'hD1); push_h2p(8'hD2); push_h2p(8'hD3);
        issue_cmd(2'd1, 16'h2000, 16'd3);
        got_req = 1'b0;
        for (int i = 0; i < 50 && !got_req; i++) begin
            @(negedge p_phi2);
            if (mem_req) got_req = 1'b1;
        end
        checks++; if (got_req !== 1'b1) begin failures++; $display("FAIL abort_req_seen: got %b expected 1", got_req); end
        abort = 1'b1;
        @(negedge p_phi2);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL abort_req_held: cycle %0d got %b expected 1", i, mem_req); end
            @(negedge p_phi2);
        end
        wait_done(50, seen);
        checks++; if (seen !== 1'b1 || done_cyc - ack_cyc !== 2) begin
            failures++; $display("FAIL abort_done_timing: seen=%b delta=%0d expected 1 2", seen, done_cyc - ack_cyc); end
        checks++; if (remaining !== 16'd2 || wr_n !== 1 || wr_data[0] !== 8'hD1) begin
            failures++; $display("FAIL abort_remaining: rem=%0d writes=%0d d0=%h expected 2 1 D1", remaining, wr_n, wr_data[0]); end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_mrd();
        bit seen;
        bit got_req;
        int done0;
        clear_logs(); ack_delay = 20;
        issue_cmd(2'd0, 16'h3000, 16'd2);
        got_req = 1'b0;
        for (int i = 0; i < 20 && !got_req; i++) begin
            @(negedge p_phi2);
            if (mem_req) got_req = 1'b1;
        end
        done0 = done_n;
        p_rst = 1'b1;
        #1;
        checks++; if (got_req !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || one_byte_mode !== 1'b1) begin
            failures++; $display("FAIL rst_mid_mrd: seen=%b req=%b busy=%b obm=%b expected 1 0 0 1", got_req, mem_req, busy, one_byte_mode); end
        @(negedge p_phi2);
        p_rst = 1'b0;
        repeat (5) @(negedge p_phi2);
        checks++; if (done_n !== done0) begin failures++; $display("FAIL rst_no_done: got %0d expected %0d", done_n, done0); end
        clear_logs(); ack_delay = 0;
        mem[16'h3000] = 8'h77;
        issue_cmd(2'd0, 16'h3000, 16'd1);
        wait_done(100, seen);
        checks++; if (seen !== 1'b1 || fw_n !== 1 || fw_data[0] !== 8'h77 || remaining !== 16'h0000) begin
            failures++; $display("FAIL rst_then_type0: done=%b writes=%0d d=%h rem=%h expected 1 1 77 0000", seen, fw_n, fw_data[0], remaining); end
    endtask

    initial begin
        test_reset();
        test_h2p_single();
        test_h2p_pair();
        test_p2h_pair_wrap();
        test_err_and_zero();
        test_abort_in_mwr();
        test_reset_mid_mrd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
